// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters, one access at a time.
// Define MEM_PORT_ARBITER_LOADER_EN to add a write-only program-loader port with top priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
`ifdef MEM_PORT_ARBITER_LOADER_EN
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {
    GR_NONE = 2'd0,
    GR_IF   = 2'd1,
`ifdef MEM_PORT_ARBITER_LOADER_EN
    GR_D    = 2'd2,
    GR_LD   = 2'd3
`else
    GR_D    = 2'd2
`endif
  } grant_t;

  localparam logic       LG_IF    = 1'b0;
  localparam logic       LG_D     = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state_r;
  grant_t     grant_r;
  grant_t     pick_s;
  logic [3:0] cnt_r;
  logic       last_grant_r;
  logic       req_we_r;

  // Winner selection: loader first (when present), then round-robin between fetch and data on a tie.
  always_comb begin
    pick_s = GR_NONE;
`ifdef MEM_PORT_ARBITER_LOADER_EN
    if (ld_req) begin
      pick_s = GR_LD;
    end else
`endif
    if (if_req && d_req) begin
      pick_s = (last_grant_r == LG_IF) ? GR_D : GR_IF;
    end else if (d_req) begin
      pick_s = GR_D;
    end else if (if_req) begin
      pick_s = GR_IF;
    end else begin
      pick_s = GR_NONE;
    end
  end

  // Access sequencer: IDLE samples, ISSUE strobes memory, WAIT counts latency, RESP acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= GR_NONE;
      cnt_r        <= 4'd0;
      last_grant_r <= LG_IF;
      req_we_r     <= 1'b0;
      if_rdata     <= {DATA_W{1'b0}};
      if_ack       <= 1'b0;
      d_rdata      <= {DATA_W{1'b0}};
      d_ack        <= 1'b0;
`ifdef MEM_PORT_ARBITER_LOADER_EN
      ld_ack       <= 1'b0;
`endif
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      busy         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          case (pick_s)
            GR_IF: begin
              mem_addr     <= if_addr;
              mem_wdata    <= {DATA_W{1'b0}};
              mem_we       <= 1'b0;
              req_we_r     <= 1'b0;
              last_grant_r <= LG_IF;
            end
            GR_D: begin
              mem_addr     <= d_addr;
              mem_wdata    <= d_wdata;
              mem_we       <= d_we;
              req_we_r     <= d_we;
              last_grant_r <= LG_D;
            end
`ifdef MEM_PORT_ARBITER_LOADER_EN
            // Loader grants leave the fetch/data fairness history untouched.
            GR_LD: begin
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
              mem_we    <= 1'b1;
              req_we_r  <= 1'b1;
            end
`endif
            default: begin
              mem_we <= 1'b0;
            end
          endcase
          if (pick_s != GR_NONE) begin
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            grant_r <= pick_s;
            state_r <= ST_ISSUE;
          end else begin
            mem_en  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          cnt_r   <= CNT_LOAD;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            case (grant_r)
              GR_IF: begin
                if_rdata <= mem_rdata;
                if_ack   <= 1'b1;
              end
              GR_D: begin
                if (!req_we_r) begin
                  d_rdata <= mem_rdata;
                end else begin
                  d_rdata <= d_rdata;
                end
                d_ack <= 1'b1;
              end
`ifdef MEM_PORT_ARBITER_LOADER_EN
              GR_LD: begin
                ld_ack <= 1'b1;
              end
`endif
              default: begin
                if_ack <= 1'b0;
              end
            endcase
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
`ifdef MEM_PORT_ARBITER_LOADER_EN
          ld_ack  <= 1'b0;
`endif
          busy    <= 1'b0;
          grant_r <= GR_NONE;
          state_r <= ST_IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          grant_r <= GR_NONE;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential two-requester arbiter that shares the multicycle CPU's single-ported unified memory between the instruction-fetch path (IF state) and the data path (LW/SW in the MEM state). It registers one request at a time, drives the memory for a fixed latency, and returns the read data with a one-cycle acknowledge to the winning requester. The block sits between the FSM/datapath memory ports and the memory macro.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `LATENCY`, default 2: cycles from the memory issue cycle to valid `mem_rdata`. Legal range is 1..15.

- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request. Held high until `if_ack`.
- `if_addr` input ADDR_W: fetch address.
- `if_rdata` output DATA_W: registered fetch data.
- `if_ack` output 1: one-cycle fetch completion pulse.
- `d_req` input 1: data request. Held high until `d_ack`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input DATA_W: store data.
- `d_rdata` output DATA_W: registered load data.
- `d_ack` output 1: one-cycle data completion pulse.
- `mem_en` output 1: memory access strobe, registered.
- `mem_we` output 1: memory write enable, registered.
- `mem_addr` output ADDR_W: memory address, registered.
- `mem_wdata` output DATA_W: memory write data, registered.
- `mem_rdata` input DATA_W: memory read data.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. 4-bit down-counter `cnt`; 2-bit `grant` (NONE, IF, D, LD); 1-bit `last_grant`.
- **IDLE:** requests are sampled only here.
  - If any request is pending: latch the winner's address, we and wdata into the `mem_*` registers, set `grant`, and go to ISSUE.
  - If no request is pending: stay in IDLE.
- **Arbitration:**
  - A single pending request wins.
  - On a tie (`if_req` and `d_req` both high), the requester that did not win last time wins.
  - `last_grant` resets to IF, so data wins the first tie.
  - `last_grant` updates on every grant.
- **ISSUE:** `mem_en` = 1 (and `mem_we` per the request) for exactly this cycle. Load `cnt` = LATENCY−1. Go to WAIT.
- **WAIT:** `mem_en` = 0 and `mem_we` = 0. Decrement `cnt` each cycle.
  - When `cnt` == 0: capture `mem_rdata` into `if_rdata` or `d_rdata` (reads only) and go to RESP.
  - Stores also traverse WAIT, so timing is uniform.
- **RESP:** pulse the granted ack for one cycle, then go to IDLE. Requests seen in RESP are ignored. This prevents double service while the requester drops its request.
- **Data registers:**
  - `if_rdata` and `d_rdata` hold their value until the next read completes on that port.
  - A store never changes `d_rdata`.
- **Protocol violations:** if a request drops before its ack, the transaction still completes and the ack still pulses. No abort.
- **Reset values:**
  - Every output resets to 0: `if_ack`, `d_ack`, `if_rdata`, `d_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
  - Internally: state = IDLE, `grant` = NONE, `cnt` = 0, `last_grant` = IF.
- **Reset mid-transaction:** abandon the transaction immediately. No ack is issued after reset release. Requesters re-request.

## Timing
- Request first high in IDLE cycle t:
  - ISSUE (`mem_en` = 1) in cycle t+1.
  - WAIT in cycles t+2 .. t+LATENCY+1.
  - `mem_rdata` is sampled at the end of cycle t+LATENCY+1.
  - ack and valid rdata in cycle t+LATENCY+2.
  - IDLE in cycle t+LATENCY+3.
- Request-to-ack latency is LATENCY+2 cycles. Service period is LATENCY+3 cycles per access.
- The memory must present valid `mem_rdata` LATENCY cycles after the ISSUE cycle and hold it through the sampling cycle.
- The losing requester keeps its request high. It is granted in the next IDLE cycle, so no starvation.

## Configuration
- Macro `MEM_PORT_ARBITER_LOADER_EN`.
- **Defined:** adds a write-only program-loader port.
  - `ld_req` input 1, `ld_addr` input ADDR_W, `ld_wdata` input DATA_W, `ld_ack` output 1 (reset 0).
  - The loader has absolute priority over fetch and data.
  - A loader grant does not update `last_grant`.
  - Timing is identical to a store.
- **Undefined:** the loader ports, the LD grant encoding and its logic are absent. Arbitration is two-way only.

## Test plan
- **Single load:** `LATENCY` = 2; `d_req` = 1, `d_we` = 0, `d_addr` = 0x40; memory returns 0xDEADBEEF. Required: `mem_en` high exactly 1 cycle with `mem_addr` = 0x40; `d_ack` 4 cycles after the request is first seen; `d_rdata` = 0xDEADBEEF; `if_ack` stays 0.
- **Simultaneous requests after reset:** `if_req` and `d_req` rise together. Required: data is serviced first; fetch is issued in the IDLE cycle right after `d_ack`. Repeat the tie: fetch wins.
- **Store:** `d_we` = 1, `d_addr` = 0x80, `d_wdata` = 0x12345678. Required: `mem_we` = 1 and `mem_wdata` = 0x12345678 in the ISSUE cycle; `d_ack` pulses; `d_rdata` is unchanged from its previous value.
- **Reset mid-transaction:** assert `rst_n` = 0 during WAIT. Required: all outputs are 0 immediately; no ack after release; `busy` = 0.
- **LATENCY = 1 back-to-back fetches:** `if_req` held high for two accesses. Required: acks 3 cycles after the first request and again 4 cycles later; exactly one ack per access.
- **Loader priority (`MEM_PORT_ARBITER_LOADER_EN` defined):** `ld_req`, `d_req` and `if_req` asserted together. Required: service order is loader, then data, then fetch.
